// File: rtl/ysyx_25040109_ifu_fetch_if.sv
// Handshake bundle between the fetch stage and its neighbours:
// the instruction memory port, the decode port and the commit feedback.
interface ysyx_25040109_ifu_fetch_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_fault;
    logic        commit_valid;
    logic [31:0] commit_npc;

    modport master (
        output mem_req_valid, mem_req_addr, mem_resp_ready,
               inst_valid, inst, pc, inst_fault,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
               inst_ready, commit_valid, commit_npc
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_resp_ready,
               inst_valid, inst, pc, inst_fault,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
               inst_ready, commit_valid, commit_npc
    );
endinterface

// File: rtl/ysyx_25040109_ifu_fetch.sv
// Multi-cycle instruction fetch: one memory read per instruction, hands
// {inst, pc, fault} to decode, then waits for commit to supply the next PC.
module ysyx_25040109_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ysyx_25040109_ifu_fetch_if.master     bus,
    output logic [CNT_W-1:0]              fetch_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        RESP  = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4
    } state_t;

    state_t             state_reg;
    logic [31:0]        pc_reg;
    logic [31:0]        inst_reg;
    logic               fault_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               req_valid_reg;
    logic               resp_ready_reg;
    logic               inst_valid_reg;

    // Handshake flags are registered alongside the state so that no input
    // ever reaches a valid/ready output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            inst_reg       <= 32'h0;
            fault_reg      <= 1'b0;
            cnt_reg        <= '0;
            req_valid_reg  <= 1'b0;
            resp_ready_reg <= 1'b0;
            inst_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg     <= FETCH;
                    req_valid_reg <= 1'b1;
                end
                FETCH: begin
                    if (bus.mem_req_ready) begin
                        state_reg      <= RESP;
                        req_valid_reg  <= 1'b0;
                        resp_ready_reg <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.mem_resp_valid) begin
                        inst_reg       <= bus.mem_resp_err ? 32'h0 : bus.mem_resp_rdata;
                        fault_reg      <= bus.mem_resp_err;
                        state_reg      <= ISSUE;
                        resp_ready_reg <= 1'b0;
                        inst_valid_reg <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.inst_ready) begin
                        cnt_reg        <= cnt_reg + 1'b1;
                        state_reg      <= WAIT;
                        inst_valid_reg <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.commit_valid) begin
                        pc_reg <= bus.commit_npc;
                        if (bus.commit_npc[1:0] == 2'b00) begin
                            state_reg     <= FETCH;
                            req_valid_reg <= 1'b1;
                        end else begin
                            // Misaligned target: report the fault without touching memory.
                            inst_reg       <= 32'h0;
                            fault_reg      <= 1'b1;
                            state_reg      <= ISSUE;
                            inst_valid_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    req_valid_reg  <= 1'b0;
                    resp_ready_reg <= 1'b0;
                    inst_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req_valid  = req_valid_reg;
    assign bus.mem_req_addr   = pc_reg;
    assign bus.mem_resp_ready = resp_ready_reg;
    assign bus.inst_valid     = inst_valid_reg;
    assign bus.inst           = inst_reg;
    assign bus.pc             = pc_reg;
    assign bus.inst_fault     = fault_reg;
    assign fetch_cnt          = cnt_reg;

endmodule

// File: tb/tb_ysyx_25040109_ifu_fetch.sv
// Directed bench for the fetch stage: expected deliveries are queued when a
// response or misaligned commit is driven and popped when decode sees them.
module tb_ysyx_25040109_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          CNT_W    = 4;
    localparam int          TMO      = 20;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] fetch_cnt;

    ysyx_25040109_ifu_fetch_if bus ();

    ysyx_25040109_ifu_fetch #(
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.master),
        .fetch_cnt (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   req_hs = 0;
    int   del_hs = 0;
    int   exp_req = 0;
    int   exp_del = 0;
    logic [CNT_W-1:0] model_cnt;

    always @(posedge clk) begin
        if (rst_n && bus.mem_req_valid && bus.mem_req_ready) req_hs++;
        if (rst_n && bus.inst_valid && bus.inst_ready) del_hs++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = 32'h0;
        bus.mem_resp_err   = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.commit_valid   = 1'b0;
        bus.commit_npc     = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"},  {31'b0, bus.mem_req_valid},  32'd0);
        check({tag, "_resp_ready"}, {31'b0, bus.mem_resp_ready}, 32'd0);
        check({tag, "_inst_valid"}, {31'b0, bus.inst_valid},     32'd0);
        check({tag, "_req_addr"},   bus.mem_req_addr,            RESET_PC);
        check({tag, "_pc"},         bus.pc,                      RESET_PC);
        check({tag, "_inst"},       bus.inst,                    32'd0);
        check({tag, "_fault"},      {31'b0, bus.inst_fault},     32'd0);
        check({tag, "_cnt"},        {{(32-CNT_W){1'b0}}, fetch_cnt}, 32'd0);
    endtask

    // Full memory transaction; commit_valid is pulsed during every stall
    // cycle to show it is ignored outside WAIT.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] rdata,
                            input logic err, input int req_dly, input int resp_dly);
        int k = 0;
        while (!bus.mem_req_valid && k < TMO) begin step(); k++; end
        check("req_seen", {31'b0, bus.mem_req_valid}, 32'd1);
        check("req_addr", bus.mem_req_addr, addr);
        for (int i = 0; i < req_dly; i++) begin
            bus.commit_valid = 1'b1;
            bus.commit_npc   = 32'h1234_5670;
            step();
            check("req_hold_addr",  bus.mem_req_addr, addr);
            check("req_hold_valid", {31'b0, bus.mem_req_valid}, 32'd1);
        end
        bus.commit_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        exp_req++;
        check("resp_ready", {31'b0, bus.mem_resp_ready}, 32'd1);
        check("req_dropped", {31'b0, bus.mem_req_valid}, 32'd0);
        for (int i = 0; i < resp_dly; i++) begin
            bus.commit_valid = 1'b1;
            bus.commit_npc   = 32'h1234_5670;
            step();
            check("resp_hold_ready", {31'b0, bus.mem_resp_ready}, 32'd1);
        end
        bus.commit_valid   = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = rdata;
        bus.mem_resp_err   = err;
        sb.push_back(err ? exp_t'{32'h0, addr, 1'b1} : exp_t'{rdata, addr, 1'b0});
        step();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_err   = 1'b0;
        check("req_count", req_hs, exp_req);
    endtask

    task automatic deliver(input int rdy_dly);
        exp_t e;
        int   k = 0;
        while (!bus.inst_valid && k < TMO) begin step(); k++; end
        check("inst_valid_seen", {31'b0, bus.inst_valid}, 32'd1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check("inst",  bus.inst, e.inst);
        check("pc",    bus.pc,   e.pc);
        check("fault", {31'b0, bus.inst_fault}, {31'b0, e.fault});
        for (int i = 0; i < rdy_dly; i++) begin
            bus.commit_valid = 1'b1;
            bus.commit_npc   = 32'h1234_5670;
            step();
            check("issue_hold_valid", {31'b0, bus.inst_valid}, 32'd1);
            check("issue_hold_inst",  bus.inst, e.inst);
            check("issue_hold_pc",    bus.pc,   e.pc);
        end
        bus.commit_valid = 1'b0;
        bus.inst_ready   = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        exp_del++;
        model_cnt = model_cnt + 1'b1;
        check("fetch_cnt", {{(32-CNT_W){1'b0}}, fetch_cnt}, {{(32-CNT_W){1'b0}}, model_cnt});
        check("deliveries", del_hs, exp_del);
        check("wait_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        $display("delivery %0d: pc=%h inst=%h fault=%0d cnt=%0d", exp_del, e.pc, e.inst, e.fault, fetch_cnt);
    endtask

    task automatic commit(input logic [31:0] npc);
        bus.commit_valid = 1'b1;
        bus.commit_npc   = npc;
        step();
        bus.commit_valid = 1'b0;
        if (npc[1:0] != 2'b00) begin
            sb.push_back(exp_t'{32'h0, npc, 1'b1});
            check("misal_no_req", {31'b0, bus.mem_req_valid}, 32'd0);
            check("misal_issue",  {31'b0, bus.inst_valid},    32'd1);
        end else begin
            check("commit_req", {31'b0, bus.mem_req_valid}, 32'd1);
        end
    endtask

    initial begin
        idle_inputs();
        model_cnt = '0;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        step();
        step();
        rst_n = 1'b1;
        check("idle_no_req", {31'b0, bus.mem_req_valid}, 32'd0);
        step();
        check("first_req", {31'b0, bus.mem_req_valid}, 32'd1);

        // Basic fetch, one-cycle memory.
        do_fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 0, 0);
        deliver(0);

        // Back-pressure on both the request and decode sides.
        commit(32'h8000_0004);
        do_fetch(32'h8000_0004, 32'h0010_0093, 1'b0, 3, 1);
        deliver(4);

        // Stray responses in WAIT must be dropped.
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'hBAD0_BAD0;
        step();
        step();
        bus.mem_resp_valid = 1'b0;
        check("wait_no_issue", {31'b0, bus.inst_valid}, 32'd0);
        check("wait_no_req",   {31'b0, bus.mem_req_valid}, 32'd0);

        // Bus error.
        commit(32'h8000_0010);
        do_fetch(32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 0, 0);
        deliver(1);

        // Misaligned commit target.
        commit(32'h8000_0006);
        deliver(0);
        check("misal_req_count", req_hs, exp_req);

        // Reset in the middle of a response phase.
        commit(32'h8000_0008);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        exp_req++;
        check("pre_rst_resp_ready", {31'b0, bus.mem_resp_ready}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        model_cnt = '0;
        exp_req = 0;
        exp_del = 0;
        req_hs  = 0;
        del_hs  = 0;
        step();
        rst_n = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'hCAFE_F00D;
        step();
        bus.mem_resp_valid = 1'b0;
        check("stale_resp_dropped", {31'b0, bus.inst_valid}, 32'd0);
        do_fetch(RESET_PC, 32'h0000_0513, 1'b0, 0, 0);
        deliver(0);

        // Counter wrap: 16 more deliveries bring the total since reset to 17.
        for (int i = 1; i <= 16; i++) begin
            commit(RESET_PC + 32'(i * 4));
            do_fetch(RESET_PC + 32'(i * 4), 32'h0000_0013 + 32'(i << 7), 1'b0, 0, 0);
            deliver(0);
        end
        check("wrap_final_cnt", {{(32-CNT_W){1'b0}}, fetch_cnt}, 32'd1);
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_25040109_ifu_fetch.md
# ysyx_25040109_ifu_fetch

Instruction fetch stage of the multi-cycle NPC core, sitting directly upstream of the decode unit. Holds the PC and issues one 32-bit instruction read per instruction over a valid/ready memory request/response pair. Delivers `{inst, pc, fault}` to decode over a valid/ready handshake. Then waits for the commit stage to supply the next PC before fetching again.

## Interface
- `RESET_PC`, 32'h8000_0000, first fetch address; bits [1:0] must be 0.
- `CNT_W`, 32, width of the delivered-instruction counter.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_req_valid`  out  1  read request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_addr`  out  32  fetch address (= PC register).
- `mem_resp_valid`  in  1  read data valid.
- `mem_resp_ready`  out  1  IFU accepts response.
- `mem_resp_rdata`  in  32  instruction word.
- `mem_resp_err`  in  1  access fault for this response.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts instruction.
- `inst`  out  32  instruction word.
- `pc`  out  32  address of `inst`.
- `inst_fault`  out  1  fetch fault (bus error or misaligned PC); `inst` = 0 when set.
- `commit_valid`  in  1  previous instruction retired; next PC supplied.
- `commit_npc`  in  32  next PC.
- `fetch_cnt`  out  CNT_W  count of instructions handed to decode.

## Operation
- FSM states: IDLE, FETCH, RESP, ISSUE, WAIT.
- IDLE: the reset state; all handshake outputs are 0. Always go to FETCH on the next cycle.
- FETCH: `mem_req_valid`=1 and `mem_req_addr`=PC.
  - On `mem_req_valid && mem_req_ready` → RESP.
  - The address is held stable while not ready.
- RESP: `mem_resp_ready`=1.
  - On `mem_resp_valid` with `mem_resp_err`=0: capture `inst`←rdata and `inst_fault`←0.
  - On `mem_resp_valid` with `mem_resp_err`=1: `inst`←0 and `inst_fault`←1.
  - Either way → ISSUE.
- ISSUE: `inst_valid`=1.
  - `inst`, `pc` and `inst_fault` are registered and stable until `inst_ready`.
  - On handshake: `fetch_cnt`+1 and → WAIT.
- WAIT: all handshake outputs are 0.
  - On `commit_valid`: PC←`commit_npc`.
  - If `commit_npc[1:0]`==0 → FETCH.
  - Else `inst`←0, `inst_fault`←1 → ISSUE. No memory request is made.
- `commit_valid` is ignored in all states except WAIT.
- `mem_resp_valid` is ignored (dropped) in all states except RESP.
- `fetch_cnt` wraps from 2^CNT_W−1 to 0.
- `pc` output = PC register.

## Timing
- Reset (async, `rst_n`=0) drives the following immediately, without waiting for a clock edge, and holds them while `rst_n`=0:
  - state=IDLE, PC=RESET_PC, `inst`=0, `inst_fault`=0, `fetch_cnt`=0.
  - `mem_req_valid`=`mem_resp_ready`=`inst_valid`=0.
  - `mem_req_addr`=`pc`=RESET_PC.
- First `mem_req_valid` is asserted in the 2nd cycle after `rst_n` rises (IDLE→FETCH).
- Reset during RESP/ISSUE aborts the transaction. A response arriving after reset release is dropped, because the FSM is not in RESP.
- Handshake outputs are pure functions of state, so there is no combinational path from any input to any valid/ready output.
- Minimum latencies, with ready inputs held high:
  - `commit_valid` in cycle N → `mem_req_valid` in N+1.
  - Response accepted in cycle M → `inst_valid` in M+1.
  - Commit to `inst_valid`: 3 cycles (N+1 req, N+2 resp, N+3 issue).
- Misaligned commit in cycle N → `inst_valid` with fault in N+1.
- One outstanding memory request at most.

## Test plan
- Reset then release, with memory returning 32'h00000413 in 1 cycle → `mem_req_addr`=32'h8000_0000; `inst_valid` carries `inst`=32'h00000413, `pc`=32'h8000_0000, `inst_fault`=0; `fetch_cnt`=1 after `inst_ready`.
- `mem_req_ready` low 3 cycles, `inst_ready` low 4 cycles → `mem_req_addr` and `inst`/`pc` held constant throughout; exactly one request and one delivery; `fetch_cnt` increments once.
- Commit `commit_npc`=32'h8000_0010, response with `mem_resp_err`=1 and rdata 32'hDEADBEEF → `inst`=0, `inst_fault`=1, `pc`=32'h8000_0010.
- Commit `commit_npc`=32'h8000_0006 → no `mem_req_valid`; `inst_valid` next cycle with `inst_fault`=1, `pc`=32'h8000_0006.
- `commit_valid` pulsed during FETCH/RESP/ISSUE, and spurious `mem_resp_valid` during WAIT → no state/PC change, no extra delivery; `rst_n` pulsed low mid-RESP → outputs return to reset values at once, and fetch restarts at RESET_PC.
- `CNT_W`=4, 17 deliveries → `fetch_cnt` reads 15 after the 15th delivery, 0 after the 16th, 1 after the 17th.
